uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receive path; counterpart to the UART transmitter. Samples the asynchronous rx line at mid-bit
//  using an internal baud counter and checks parity and the first stop bit. Delivers each good
//  character on an AXI-Stream master port. Sits between the FPGA rx pin and downstream logic.
// PARAMETERS
//  system_clk  50_000000  system clock frequency, Hz
//  band_rate   9600       baud rate; N = system_clk/band_rate clocks per bit, H = N/2
//  data_bits   8          data bits per character, 5..8
//  check_mode  1          0 none, 1 even, 2 odd, 3 fixed-0, 4 fixed-1 parity bit
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous reset, active high
//  rx_en          in   1  receiver enable, active high
//  rx             in   1  UART rx pin, asynchronous, idle high
//  m_axis_tdata   out  8  received character, LSB-aligned, upper (8-data_bits) bits 0
//  m_axis_tvalid  out  1  character valid
//  m_axis_tready  in   1  downstream accept
//  parity_err     out  1  1-clk pulse: parity mismatch, character dropped
//  frame_err      out  1  1-clk pulse: stop bit sampled 0, character dropped
//  overrun_err    out  1  1-clk pulse: good character completed while tvalid=1, new character dropped
//  busy           out  1  high in any state other than IDLE
// BEHAVIOUR
//  - rx passes through a 2-FF synchronizer (rx_s) before use; all timing below is relative to rx_s.
//  - On reset all outputs are 0 and the state is IDLE. The pending character, counters and the synchronizer
//    (preset to 1) are cleared. Reset mid-frame abandons the frame.
//  - State: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, plus BREAK. A bit counter cnt runs 0..N-1.
//  - IDLE: when rx_en=1 and rx_s=0, go to START with cnt=0.
//  - START: at cnt=H-1, sample rx_s. If it is 1, the start was a glitch: return to IDLE and report nothing.
//    If it is 0, clear cnt and go to DATA.
//  - DATA: sample rx_s at cnt=N-1 into shift register bit i, LSB first. After data_bits samples, go to
//    PARITY, or go to STOP when check_mode=0.
//  - PARITY: sample at cnt=N-1. The expected value is ^data (mode 1), ~^data (mode 2), 0 (mode 3) or
//    1 (mode 4). On mismatch set the internal flag perr.
//  - STOP: sample at cnt=N-1, which is mid first stop bit. Only the first stop bit is checked.
//      - sample 0: pulse frame_err (takes precedence; parity_err is not also pulsed), go to BREAK.
//      - sample 1 and perr set: pulse parity_err, go to IDLE.
//      - sample 1 and perr clear:
//          - if tvalid=0, or tvalid=1 and tready=1 in the same cycle: load tdata and set tvalid on the
//            next clock.
//          - otherwise (tvalid=1, tready=0): pulse overrun_err; the held tdata is unchanged.
//        Then go to IDLE.
//  - BREAK: wait for rx_s=1, then go to IDLE. A held-low line never retriggers the receiver.
//  - Latency: tvalid rises 1 clk after the stop-bit sample, i.e. (1+data_bits+P)*N+H-1+1 clks after rx_s
//    falls (P=1 if parity is enabled).
//  - AXIS: tdata and tvalid are stable while tvalid=1 and tready=0. tvalid clears on a tvalid&tready clock
//    unless a new character is loaded in that same clock, in which case tvalid stays 1 with the new data.
//  - Buffer depth is 1 character. A receiver in IDLE can accept a new start bit on the clock after the
//    stop sample.
//  - rx_en=0 in any state other than IDLE: abort to IDLE next clock and report nothing. A held tvalid/tdata
//    is kept.
//  - The counter is $clog2(N) bits wide. N is at least 4 by construction.
// TESTING (system_clk=160, band_rate=10 -> N=16, H=8; data_bits=8, check_mode=1 unless noted)
//  1 Frame 0xA5 with parity 0, tready=1 -> one tvalid pulse with tdata=0xA5; all error flags stay 0;
//    busy falls with the stop sample.
//  2 Frame 0xA5 with parity bit 1 -> parity_err pulse, tvalid stays 0; the next good frame 0x5A is received.
//  3 Frame 0x3C with stop bit 0, line held low 40 clks -> one frame_err pulse and no tvalid; the receiver
//    stays in BREAK until high; the next frame 0x3C is received.
//  4 rx low for 5 clks then high -> busy pulses, no tvalid and no error flags.
//  5 tready=0, frames 0x11 then 0x22 -> tdata holds 0x11 and overrun_err pulses once. Raising tready
//    transfers 0x11, then tvalid=0.
//  6 rst asserted during data bit 3 -> all outputs 0; then check_mode=0, data_bits=5, frame 0x1F ->
//    tdata=0x1F.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised rx, mid-bit sampling, parity + first-stop check, 1-deep AXIS output.
// Latency: tvalid 1 clk after the stop sample; backpressure: one held character, a later good one is dropped with overrun_err.
module uart_rx #(
    parameter int system_clk = 50_000_000,
    parameter int band_rate  = 9600,
    parameter int data_bits  = 8,
    parameter int check_mode = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       rx,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam int N  = system_clk / band_rate;
    localparam int H  = N / 2;
    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, shreg_n;
    logic          perr, perr_n;
    logic          rx_meta, rx_s;
    logic [7:0]    tdata;
    logic          tvalid;
    logic          pe, fe, oe;
    logic          pe_n, fe_n, oe_n;
    logic          load;
    logic          par_exp;
    logic          cnt_last, cnt_half;

    assign cnt_last = (cnt == CW'(N - 1));
    assign cnt_half = (cnt == CW'(H - 1));

    // shreg bits above data_bits are always zero, so the reduction covers the data only
    always_comb begin
        case (check_mode)
            1:       par_exp = ^shreg;
            2:       par_exp = ~^shreg;
            4:       par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_idx;
        shreg_n = shreg;
        perr_n  = perr;
        pe_n    = 1'b0;
        fe_n    = 1'b0;
        oe_n    = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx_en && !rx_s) begin
                    state_n = START;
                    bit_n   = '0;
                    shreg_n = '0;
                    perr_n  = 1'b0;
                end
            end
            START: begin
                if (cnt_half) begin
                    cnt_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_n            = '0;
                    shreg_n[bit_idx] = rx_s;
                    bit_n            = bit_idx + 1'b1;
                    if (bit_idx == 3'(data_bits - 1))
                        state_n = (check_mode == 0) ? STOP : PARITY;
                end
            end
            PARITY: begin
                if (cnt_last) begin
                    cnt_n   = '0;
                    perr_n  = (rx_s != par_exp);
                    state_n = STOP;
                end
            end
            STOP: begin
                if (cnt_last) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (!rx_s) begin
                        fe_n    = 1'b1;
                        state_n = BRK;
                    end else if (perr) begin
                        pe_n = 1'b1;
                    end else if (!tvalid || m_axis_tready) begin
                        load = 1'b1;
                    end else begin
                        oe_n = 1'b1;
                    end
                end
            end
            BRK: begin
                cnt_n = '0;
                if (rx_s)
                    state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
        // disabling mid-frame abandons it silently; a held character survives
        if (state != IDLE && !rx_en) begin
            state_n = IDLE;
            cnt_n   = '0;
            pe_n    = 1'b0;
            fe_n    = 1'b0;
            oe_n    = 1'b0;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            perr    <= 1'b0;
            tdata   <= '0;
            tvalid  <= 1'b0;
            pe      <= 1'b0;
            fe      <= 1'b0;
            oe      <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            perr    <= perr_n;
            pe      <= pe_n;
            fe      <= fe_n;
            oe      <= oe_n;
            if (load) begin
                tdata  <= shreg;
                tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = tdata;
    assign m_axis_tvalid = tvalid;
    assign parity_err    = pe;
    assign frame_err     = fe;
    assign overrun_err   = oe;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: dut_a (8 bits, even parity) and dut_b (5 bits, no parity) driven at pin level.
module tb_uart_rx;

    localparam int N = 16;
    localparam int H = 8;

    logic       clk;
    logic       rst;
    logic       rx_en;
    logic       tready;
    logic       rx_a, rx_b;
    logic [7:0] a_tdata, b_tdata;
    logic       a_tvalid, b_tvalid;
    logic       a_pe, a_fe, a_oe, a_busy;
    logic       b_pe, b_fe, b_oe, b_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // monitor state, written only by the negedge monitors
    logic [7:0] da[0:255];
    logic [7:0] db[0:255];
    int na = 0, nb = 0;
    int pe_a = 0, fe_a = 0, oe_a = 0;
    int pe_b = 0, fe_b = 0, oe_b = 0;
    int a_rise_cyc = -1;
    logic a_rise_busy = 1'b1;
    logic a_tvalid_q = 1'b0;

    uart_rx #(.system_clk(160), .band_rate(10), .data_bits(8), .check_mode(1)) dut_a (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx(rx_a),
        .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(tready),
        .parity_err(a_pe), .frame_err(a_fe), .overrun_err(a_oe), .busy(a_busy)
    );

    uart_rx #(.system_clk(160), .band_rate(10), .data_bits(5), .check_mode(0)) dut_b (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx(rx_b),
        .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(tready),
        .parity_err(b_pe), .frame_err(b_fe), .overrun_err(b_oe), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_tvalid && tready) begin da[na[7:0]] = a_tdata; na = na + 1; end
        if (a_pe) pe_a = pe_a + 1;
        if (a_fe) fe_a = fe_a + 1;
        if (a_oe) oe_a = oe_a + 1;
        if (a_tvalid && !a_tvalid_q) begin a_rise_cyc = cyc; a_rise_busy = a_busy; end
        a_tvalid_q = a_tvalid;
    end

    always @(negedge clk) begin
        if (b_tvalid && tready) begin db[nb[7:0]] = b_tdata; nb = nb + 1; end
        if (b_pe) pe_b = pe_b + 1;
        if (b_fe) fe_b = fe_b + 1;
        if (b_oe) oe_b = oe_b + 1;
    end

    // parity bit a transmitter would send for the low nbits of d
    function automatic logic par_bit(input logic [7:0] d, input int nbits, input int mode);
        int ones = 0;
        for (int i = 0; i < nbits; i++) ones += int'(d[i]);
        case (mode)
            1:       return logic'(ones % 2);
            2:       return logic'((ones + 1) % 2);
            4:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // every drive task starts and ends 1ns after a rising edge
    task automatic drv(input bit sel, input logic v, input int n);
        if (sel) rx_b = v; else rx_a = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input int nbits, input int mode,
                              input bit bad_par, input logic stop_v);
        drv(sel, 1'b0, N);
        for (int i = 0; i < nbits; i++) drv(sel, d[i], N);
        if (mode != 0) drv(sel, par_bit(d, nbits, mode) ^ bad_par, N);
        drv(sel, stop_v, N);
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_en = 1'b1; tready = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %0b want 0", a_tvalid); end
        total++; if (a_tdata !== 8'h00) begin bad++; $display("FAIL reset_tdata: got %h want 00", a_tdata); end
        total++; if ({a_pe, a_fe, a_oe, a_busy} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {a_pe, a_fe, a_oe, a_busy}); end
        total++; if ({b_tvalid, b_pe, b_fe, b_oe, b_busy} !== 5'b0) begin bad++; $display("FAIL reset_b: got %b want 00000", {b_tvalid, b_pe, b_fe, b_oe, b_busy}); end
        rst = 1'b0;
        drv(0, 1'b1, 4);
        total++; if ({a_tvalid, a_busy} !== 2'b0) begin bad++; $display("FAIL post_reset_idle: got %b want 00", {a_tvalid, a_busy}); end
    endtask

    task automatic test_good_frame;
        int n0 = na, p0 = pe_a, f0 = fe_a, o0 = oe_a;
        int t0 = cyc;
        int lat;
        drv(0, 1'b0, N);
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL good_busy_mid: got %0b want 1", a_busy); end
        for (int i = 0; i < 8; i++) drv(0, 1'(8'hA5 >> i), N);
        drv(0, par_bit(8'hA5, 8, 1), N);
        drv(0, 1'b1, N);
        drv(0, 1'b1, 4);
        total++; if (na - n0 != 1) begin bad++; $display("FAIL good_count: got %0d want 1", na - n0); end
        total++; if (da[n0[7:0]] !== 8'hA5) begin bad++; $display("FAIL good_data: got %h want a5", da[n0[7:0]]); end
        total++; if ({pe_a - p0, fe_a - f0, oe_a - o0} !== {32'd0, 32'd0, 32'd0}) begin bad++; $display("FAIL good_errs: got pe=%0d fe=%0d oe=%0d want 0", pe_a - p0, fe_a - f0, oe_a - o0); end
        total++; if (a_rise_busy !== 1'b0) begin bad++; $display("FAIL good_busy_at_valid: got %0b want 0", a_rise_busy); end
        // rx_s falls 2 clks after the pin; allow one clock of edge-counting ambiguity on top of the formula
        lat = a_rise_cyc - t0;
        total++; if (lat < 2 + 10 * N + H || lat > 2 + 10 * N + H + 1) begin bad++; $display("FAIL good_latency: got %0d want %0d..%0d", lat, 2 + 10 * N + H, 2 + 10 * N + H + 1); end
    endtask

    task automatic test_parity_err;
        int n0 = na, p0 = pe_a;
        send_frame(0, 8'hA5, 8, 1, 1'b1, 1'b1);
        drv(0, 1'b1, 4);
        total++; if (pe_a - p0 != 1) begin bad++; $display("FAIL parity_pulse: got %0d want 1", pe_a - p0); end
        total++; if (na - n0 != 0) begin bad++; $display("FAIL parity_dropped: got %0d chars want 0", na - n0); end
        send_frame(0, 8'h5A, 8, 1, 1'b0, 1'b1);
        drv(0, 1'b1, 4);
        total++; if (na - n0 != 1 || da[n0[7:0]] !== 8'h5A) begin bad++; $display("FAIL parity_next: got n=%0d d=%h want n=1 d=5a", na - n0, da[n0[7:0]]); end
        total++; if (pe_a - p0 != 1) begin bad++; $display("FAIL parity_next_err: got %0d want 1", pe_a - p0); end
    endtask

    task automatic test_frame_err;
        int n0 = na, f0 = fe_a, p0 = pe_a;
        send_frame(0, 8'h3C, 8, 1, 1'b0, 1'b0);
        drv(0, 1'b0, 40);
        total++; if (fe_a - f0 != 1) begin bad++; $display("FAIL frame_pulse: got %0d want 1", fe_a - f0); end
        total++; if (na - n0 != 0 || pe_a != p0) begin bad++; $display("FAIL frame_no_char: got n=%0d pe=%0d want 0", na - n0, pe_a - p0); end
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL frame_break_busy: got %0b want 1", a_busy); end
        drv(0, 1'b1, N);
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL frame_break_exit: got %0b want 0", a_busy); end
        send_frame(0, 8'h3C, 8, 1, 1'b0, 1'b1);
        drv(0, 1'b1, 4);
        total++; if (na - n0 != 1 || da[n0[7:0]] !== 8'h3C || fe_a - f0 != 1) begin bad++; $display("FAIL frame_next: got n=%0d d=%h fe=%0d want n=1 d=3c fe=1", na - n0, da[n0[7:0]], fe_a - f0); end
    endtask

    task automatic test_glitch;
        int n0 = na, p0 = pe_a, f0 = fe_a, o0 = oe_a;
        drv(0, 1'b0, 5);
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy: got %0b want 1", a_busy); end
        drv(0, 1'b1, 2 * N);
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL glitch_idle: got %0b want 0", a_busy); end
        total++; if (na != n0 || pe_a != p0 || fe_a != f0 || oe_a != o0) begin bad++; $display("FAIL glitch_silent: got n=%0d pe=%0d fe=%0d oe=%0d want 0", na - n0, pe_a - p0, fe_a - f0, oe_a - o0); end
    endtask

    task automatic test_overrun;
        int n0 = na, o0 = oe_a;
        tready = 1'b0;
        send_frame(0, 8'h11, 8, 1, 1'b0, 1'b1);
        send_frame(0, 8'h22, 8, 1, 1'b0, 1'b1);
        drv(0, 1'b1, 4);
        total++; if (a_tvalid !== 1'b1 || a_tdata !== 8'h11) begin bad++; $display("FAIL overrun_hold: got v=%0b d=%h want v=1 d=11", a_tvalid, a_tdata); end
        total++; if (oe_a - o0 != 1) begin bad++; $display("FAIL overrun_pulse: got %0d want 1", oe_a - o0); end
        tready = 1'b1;
        drv(0, 1'b1, 3);
        total++; if (na - n0 != 1 || da[n0[7:0]] !== 8'h11) begin bad++; $display("FAIL overrun_xfer: got n=%0d d=%h want n=1 d=11", na - n0, da[n0[7:0]]); end
        total++; if (a_tvalid !== 1'b0) begin bad++; $display("FAIL overrun_drain: got %0b want 0", a_tvalid); end
    endtask

    task automatic test_rx_en;
        int n0 = na, p0 = pe_a, f0 = fe_a;
        drv(0, 1'b0, N);
        for (int i = 0; i < 4; i++) drv(0, 1'b0, N);
        rx_en = 1'b0;
        drv(0, 1'b0, 2);
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rxen_abort: got %0b want 0", a_busy); end
        drv(0, 1'b1, 2 * N);
        send_frame(0, 8'h00, 8, 1, 1'b0, 1'b0);
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rxen_blocked: got %0b want 0", a_busy); end
        rx_en = 1'b1;
        drv(0, 1'b1, 2 * N);
        total++; if (na != n0 || pe_a != p0 || fe_a != f0) begin bad++; $display("FAIL rxen_silent: got n=%0d pe=%0d fe=%0d want 0", na - n0, pe_a - p0, fe_a - f0); end
    endtask

    task automatic test_reset_mid_frame;
        int n0, m0 = nb;
        tready = 1'b0;
        send_frame(0, 8'h77, 8, 1, 1'b0, 1'b1);
        drv(0, 1'b1, 2);
        total++; if (a_tvalid !== 1'b1) begin bad++; $display("FAIL rstmid_pre_hold: got %0b want 1", a_tvalid); end
        drv(0, 1'b0, N);
        for (int i = 0; i < 3; i++) drv(0, 1'b0, N);
        drv(0, 1'b0, N / 2);
        rst = 1'b1;
        drv(0, 1'b1, 2);
        total++; if ({a_tvalid, a_tdata, a_pe, a_fe, a_oe, a_busy} !== 13'b0) begin bad++; $display("FAIL rstmid_outputs: got v=%0b d=%h e=%b busy=%0b want all 0", a_tvalid, a_tdata, {a_pe, a_fe, a_oe}, a_busy); end
        rst = 1'b0;
        tready = 1'b1;
        n0 = na;
        drv(0, 1'b1, 2 * N);
        total++; if (na != n0 || a_tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_abandoned: got n=%0d v=%0b want 0", na - n0, a_tvalid); end
        send_frame(1, 8'h1F, 5, 0, 1'b0, 1'b1);
        drv(1, 1'b1, 4);
        total++; if (nb - m0 != 1 || db[m0[7:0]] !== 8'h1F) begin bad++; $display("FAIL b5_data: got n=%0d d=%h want n=1 d=1f", nb - m0, db[m0[7:0]]); end
        total++; if (pe_b + fe_b + oe_b != 0) begin bad++; $display("FAIL b5_errs: got %0d want 0", pe_b + fe_b + oe_b); end
    endtask

    // random good / bad-parity / bad-stop frames, back to back where the line allows
    task automatic test_random;
        logic [7:0] expq[$];
        logic [7:0] expb[$];
        int n0 = na, p0 = pe_a, f0 = fe_a, m0 = nb;
        int exp_pe = 0, exp_fe = 0;
        for (int k = 0; k < 16; k++) begin
            logic [7:0] d = 8'($urandom);
            int kind = int'($urandom_range(0, 3));
            if (kind == 2) begin
                send_frame(0, d, 8, 1, 1'b1, 1'b1);
                exp_pe++;
            end else if (kind == 3) begin
                send_frame(0, d, 8, 1, 1'b0, 1'b0);
                drv(0, 1'b0, int'($urandom_range(1, 30)));
                drv(0, 1'b1, N);
                exp_fe++;
            end else begin
                send_frame(0, d, 8, 1, 1'b0, 1'b1);
                expq.push_back(d);
            end
        end
        drv(0, 1'b1, 4);
        total++; if (na - n0 != expq.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", na - n0, expq.size()); end
        total++; if (pe_a - p0 != exp_pe || fe_a - f0 != exp_fe) begin bad++; $display("FAIL rand_errs: got pe=%0d fe=%0d want pe=%0d fe=%0d", pe_a - p0, fe_a - f0, exp_pe, exp_fe); end
        for (int i = 0; i < expq.size() && i < na - n0; i++) begin
            total++; if (da[8'(n0 + i)] !== expq[i]) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", i, da[8'(n0 + i)], expq[i]); end
        end
        for (int k = 0; k < 6; k++) begin
            logic [7:0] d = 8'($urandom);
            send_frame(1, d, 5, 0, 1'b0, 1'b1);
            expb.push_back(d & 8'h1F);
        end
        drv(1, 1'b1, 4);
        total++; if (nb - m0 != expb.size()) begin bad++; $display("FAIL randb_count: got %0d want %0d", nb - m0, expb.size()); end
        for (int i = 0; i < expb.size() && i < nb - m0; i++) begin
            total++; if (db[8'(m0 + i)] !== expb[i]) begin bad++; $display("FAIL randb_data[%0d]: got %h want %h", i, db[8'(m0 + i)], expb[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_parity_err;
        test_frame_err;
        test_glitch;
        test_overrun;
        test_rx_en;
        test_reset_mid_frame;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
